div_unit: RTL and testbench

- Multi-cycle 32-bit divider in the EX stage, downstream of the ALU-control decoder.
- Started when the EX-stage control is the signed or unsigned divide operation (the DIV/DIVU op codes from the shared defines header).
- Runs radix-2 restoring division over 32 cycles, then presents remainder/quotient for the HI/LO write.
- Drives a stall request to the hazard unit while busy.

---
 rtl/div_unit_pkg.sv | 17 +
 rtl/div_step.sv | 29 ++
 rtl/div_unit.sv | 127 ++++++++++++
 tb/tb_div_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared defines for the EX-stage divider: ALU-control op codes for DIV/DIVU
// and the divider FSM state encodings.
package div_unit_pkg;

    localparam int ALUCTL_W = 5;

    // The EX-stage glue derives start/signed_div from these alucontrol values.
    localparam logic [ALUCTL_W-1:0] ALU_DIV  = 5'd14;
    localparam logic [ALUCTL_W-1:0] ALU_DIVU = 5'd15;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration, purely combinational.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The extra bit keeps the compare exact when the divisor uses the top bit.
    assign shifted = {rem, q[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};

    always_comb begin
        if (!diff[WIDTH]) begin
            rem_next = diff[WIDTH-1:0];
            q_next   = {q[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            q_next   = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned restoring divider with HI/LO result and stall.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips CALC and finishes at T+1.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int LAT_BITS = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             annul,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [LAT_BITS-1:0] LAST_CNT = LAT_BITS'(WIDTH - 1);

    div_state_e state_q, state_d;

    logic [LAT_BITS-1:0] count_q;
    logic [WIDTH-1:0]    rem_q, quo_q, dvsr_q, a_q;
    logic                a_neg_q, b_neg_q, bzero_q;
    logic [WIDTH-1:0]    hi_q, lo_q;

    logic             fire;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH-1:0] rem_next, q_next;
    logic [WIDTH-1:0] quo_fix, rem_fix, res_hi, res_lo;

    assign fire  = (state_q == DIV_IDLE) && start && !annul;
    assign a_neg = signed_div && a[WIDTH-1];
    assign b_neg = signed_div && b[WIDTH-1];
    assign a_abs = a_neg ? -a : a;
    assign b_abs = b_neg ? -b : b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .q        (quo_q),
        .divisor  (dvsr_q),
        .rem_next (rem_next),
        .q_next   (q_next)
    );

    // 0x80000000 / -1 needs no special case: the negate wraps back to itself.
    assign quo_fix = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
    assign rem_fix = a_neg_q ? -rem_q : rem_q;
    assign res_lo  = bzero_q ? '1  : quo_fix;
    assign res_hi  = bzero_q ? a_q : rem_fix;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= DIV_IDLE;
        else         state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: begin
                if (fire) begin
`ifdef DIV_ZERO_FAST_EN
                    state_d = (b == '0) ? DIV_DONE : DIV_CALC;
`else
                    state_d = DIV_CALC;
`endif
                end
            end
            DIV_CALC: begin
                if (annul)                  state_d = DIV_IDLE;
                else if (count_q == LAST_CNT) state_d = DIV_DONE;
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_comb begin
        busy  = ((state_q == DIV_IDLE) && start) || (state_q == DIV_CALC);
        valid = (state_q == DIV_DONE) && !annul;
        hi    = valid ? res_hi : hi_q;
        lo    = valid ? res_lo : lo_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            a_q     <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            bzero_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            if (fire) begin
                count_q <= '0;
                rem_q   <= '0;
                quo_q   <= a_abs;
                dvsr_q  <= b_abs;
                a_q     <= a;
                a_neg_q <= a_neg;
                b_neg_q <= b_neg;
                bzero_q <= (b == '0);
            end else if (state_q == DIV_CALC) begin
                count_q <= count_q + LAT_BITS'(1);
                rem_q   <= rem_next;
                quo_q   <= q_next;
            end
            if (valid) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signs, overflow,
// divide-by-zero, annul, ignored start and asynchronous reset.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic [31:0] a, b;
    logic        annul;
    logic        busy, valid;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    div_unit #(.WIDTH(32), .LAT_BITS(6)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .annul      (annul),
        .busy       (busy),
        .valid      (valid),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    // Issue one divide at the next negedge (cycle 0) and watch it to completion.
    // poke_cyc >= 1 injects a competing start that must be ignored.
    task automatic do_op(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input int exp_lat, input string name, input int poke_cyc);
        int got_lat = -1;
        int busy_err = 0;
        int vcnt = 0;
        logic [31:0] got_lo = 'x;
        logic [31:0] got_hi = 'x;
        @(negedge clk);
        start = 1'b1; signed_div = sd; a = av; b = bv;
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_on_start got=%b exp=1", name, busy);
        end
        for (int cyc = 1; cyc <= exp_lat + 4; cyc++) begin
            @(negedge clk);
            if (cyc == poke_cyc) begin
                start = 1'b1; signed_div = 1'b0; a = 32'd9; b = 32'd3;
            end else begin
                start = 1'b0;
            end
            #1;
            if (busy !== 1'(cyc < exp_lat)) busy_err++;
            if (valid === 1'b1) begin
                vcnt++;
                if (got_lat < 0) begin
                    got_lat = cyc; got_lo = lo; got_hi = hi;
                end
            end
        end
        total++;
        if (got_lat != exp_lat) begin
            bad++;
            $display("FAIL %s latency got=%0d exp=%0d", name, got_lat, exp_lat);
        end
        total++;
        if (vcnt != 1) begin
            bad++;
            $display("FAIL %s valid_pulses got=%0d exp=1", name, vcnt);
        end
        total++;
        if (busy_err != 0) begin
            bad++;
            $display("FAIL %s busy_profile bad_cycles=%0d exp=0", name, busy_err);
        end
        total++;
        if (got_lo !== exp_lo || got_hi !== exp_hi) begin
            bad++;
            $display("FAIL %s result lo=%h hi=%h exp lo=%h hi=%h", name, got_lo, got_hi, exp_lo, exp_hi);
        end
        total++;
        if (lo !== exp_lo || hi !== exp_hi) begin
            bad++;
            $display("FAIL %s hold lo=%h hi=%h exp lo=%h hi=%h", name, lo, hi, exp_lo, exp_hi);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; signed_div = 1'b0; a = '0; b = '0; annul = 1'b0;
        #1;
        total++;
        if ({busy, valid, hi, lo} !== '0) begin
            bad++;
            $display("FAIL reset_state busy=%b valid=%b hi=%h lo=%h exp all 0", busy, valid, hi, lo);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({busy, valid, hi, lo} !== '0) begin
            bad++;
            $display("FAIL post_reset_idle busy=%b valid=%b hi=%h lo=%h exp all 0", busy, valid, hi, lo);
        end
    endtask

    task automatic test_divu();
        do_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, "divu_100_7", -1);
        do_op(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 33, "divu_big", -1);
    endtask

    task automatic test_signed();
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, "div_neg7_2", -1);
        do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, "div_7_neg2", -1);
        do_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 33, "div_neg7_neg2", -1);
    endtask

    task automatic test_overflow();
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, "div_overflow", -1);
    endtask

    task automatic test_div_zero();
        do_op(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, ZLAT, "divu_by_zero", -1);
        do_op(1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, ZLAT, "div_by_zero", -1);
    endtask

    task automatic test_start_ignored();
        do_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, "start_in_calc", 5);
    endtask

    task automatic test_annul();
        int vcnt = 0;
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            annul = (cyc == 10);
            #1;
            if (valid === 1'b1) vcnt++;
        end
        annul = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL annul_busy got=%b exp=0", busy);
        end
        total++;
        if (vcnt != 0) begin
            bad++;
            $display("FAIL annul_valid pulses=%0d exp=0", vcnt);
        end
        total++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            bad++;
            $display("FAIL annul_hold lo=%h hi=%h exp lo=%h hi=%h", lo, hi, 32'd14, 32'd2);
        end
        do_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, "annul_restart", -1);
    endtask

    task automatic test_async_reset();
        int vcnt = 0;
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2;
        resetn = 1'b0;
        #1;
        total++;
        if ({busy, valid, hi, lo} !== '0) begin
            bad++;
            $display("FAIL async_reset busy=%b valid=%b hi=%h lo=%h exp all 0", busy, valid, hi, lo);
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            #1;
            if (valid === 1'b1) vcnt++;
        end
        total++;
        if (vcnt != 0) begin
            bad++;
            $display("FAIL reset_spurious_valid pulses=%0d exp=0", vcnt);
        end
        do_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, "after_reset", -1);
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_overflow();
        test_div_zero();
        test_start_ignored();
        test_annul();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
